// File: rtl/csa_sub_8_seq.sv
// csa_sub_8_seq: chunk-serial subtractor, LSB chunk first, with a registered borrow between chunks.
module csa_sub_8_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d, done_q, done_d;
  logic [CHUNK:0] sub;
  logic [WIDTH+CHUNK-1:0] acc_sh;
  // Operands shift right each cycle, so the active chunk is always the low CHUNK bits
  // and on the last chunk those low bits carry the original sign bits.
  always_comb begin
    sub = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(br_q);
    acc_sh = {sub[CHUNK-1:0], acc_q} >> CHUNK;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    br_d = br_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d = a;
        b_d = b;
        br_d = 1'b0;
        cnt_d = '0;
        state_d = RUN;
      end
    end else begin
      a_d = a_q >> CHUNK;
      b_d = b_q >> CHUNK;
      acc_d = acc_sh[WIDTH-1:0];
      br_d = sub[CHUNK];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        diff_d = acc_sh[WIDTH-1:0];
        borrow_d = sub[CHUNK];
        ovf_d = (a_q[CHUNK-1] != b_q[CHUNK-1]) && (sub[CHUNK-1] != a_q[CHUNK-1]);
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign diff = diff_q;
  assign borrow = borrow_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_csa_sub_8_seq.sv
// tb_csa_sub_8_seq: directed vectors pushed to a scoreboard, checked by an independent done monitor.
module tb_csa_sub_8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic busy, done, borrow, ovf;
  logic [7:0] diff;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic br;
    logic ov;
    int edge_n;
  } exp_t;
  exp_t sb[$];
  csa_sub_8_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask
  // Monitor: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", diff, e.d);
        check("borrow", borrow, e.br);
        check("ovf", ovf, e.ov);
        check("latency", cyc - e.edge_n, 2);
        check("diff_plus_b", 8'(diff + e.b), e.a);
      end
    end
  end
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] d,
                        input logic br, input logic ov);
    exp_t e;
    start = 1'b1;
    a = ta;
    b = tb;
    e.a = ta;
    e.b = tb;
    e.d = d;
    e.br = br;
    e.ov = ov;
    e.edge_n = cyc + 1;
    sb.push_back(e);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask
  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] d,
                    input logic br, input logic ov);
    @(negedge clk);
    launch(ta, tb, d, br, ov);
    @(negedge clk);
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    check("busy_after_start", busy, 1);
    wait_done();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outs", {diff, borrow, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
    op(8'h9C, 8'h37, 8'h65, 1'b0, 1'b1);
    @(negedge clk);
    check("outs_hold", {diff, borrow, ovf}, {8'h65, 1'b0, 1'b1});
    // Ignored start while busy, then back-to-back start on the done cycle.
    launch(8'h12, 8'h34, 8'hDE, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 8'hC3;
    b = 8'hE8;
    @(negedge clk);
    start = 1'b0;
    check("busy_run", busy, 1);
    wait_done();
    launch(8'hAB, 8'hE8, 8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("busy_b2b", busy, 1);
    wait_done();
    // Reset after one chunk of an operation: no done may follow.
    @(negedge clk);
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outs", {diff, borrow, ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_idle", busy, 0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic [8:0] r;
      ra = 8'($urandom);
      rb = 8'($urandom);
      r = {1'b0, ra} - {1'b0, rb};
      op(ra, rb, r[7:0], r[8], (ra[7] != rb[7]) && (r[7] != ra[7]));
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
